// File: rtl/spi_register_controller_pkg.sv
// Shared definitions for the SPI register-port sequencer: sequencer state
// encoding and the default status word presented while no data is pending.
package spi_register_controller_pkg;

    localparam int         DEFAULT_WIDTH       = 8;
    localparam logic [7:0] DEFAULT_STATUS_WORD = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_WR       = 3'd2,
        ST_RD_FETCH = 3'd3,
        ST_RD_LOAD  = 3'd4,
        ST_RD_WAIT  = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/spi_register_controller.sv
// Transaction sequencer behind the SPI slave: the first word of each
// chip-select frame is a command (write flag + start address); later words
// become register writes, or dummy words that trigger the next read-ahead.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no frame open, value_miso holds the status word
// ST_CMD      | frame open, waiting for the command word
// ST_WR       | every data word becomes a register write, address advances
// ST_RD_FETCH | read strobe issued, register data arrives next cycle
// ST_RD_LOAD  | register data captured into value_miso, address advances
// ST_RD_WAIT  | waiting for the master's dummy word to fetch the next one
module spi_register_controller
    import spi_register_controller_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] STATUS_WORD = WIDTH'(DEFAULT_STATUS_WORD)
) (
    input  logic             system_clk,
    input  logic             system_rst_n,
    input  logic             cs_start,
    input  logic             cs_stop,
    input  logic             value_valid,
    input  logic [WIDTH-1:0] value_mosi,
    output logic [WIDTH-1:0] value_miso,
    output logic [WIDTH-2:0] reg_addr,
    output logic [WIDTH-1:0] reg_wdata,
    output logic             reg_we,
    output logic             reg_re,
    input  logic [WIDTH-1:0] reg_rdata,
    output logic             busy,
    output logic             overrun
);

    localparam int AW            = WIDTH - 1;
    localparam int CMD_WRITE_BIT = WIDTH - 1;

    ctrl_state_t state;

    // busy is a straight decode of the state register.
    assign busy = (state != ST_IDLE);

    // Sequencer: frame control, command decode, write strobes and read-ahead.
    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state      <= ST_IDLE;
            value_miso <= STATUS_WORD;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            // The write strobe must see the current address, so the
            // post-write increment happens in the cycle after the strobe.
            if (reg_we) begin
                reg_addr <= reg_addr + AW'(1);
            end

            if (cs_start) begin
                state      <= ST_CMD;
                overrun    <= 1'b0;
                value_miso <= STATUS_WORD;
            end else if (cs_stop) begin
                // A word completing together with the frame end still lands.
                if (state == ST_WR && value_valid) begin
                    reg_wdata <= value_mosi;
                    reg_we    <= 1'b1;
                end
                state      <= ST_IDLE;
                value_miso <= STATUS_WORD;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (value_valid) begin
                            reg_addr <= value_mosi[AW-1:0];
                            if (value_mosi[CMD_WRITE_BIT]) begin
                                state <= ST_WR;
                            end else begin
                                reg_re <= 1'b1;
                                state  <= ST_RD_FETCH;
                            end
                        end
                    end
                    ST_WR: begin
                        if (value_valid) begin
                            reg_wdata <= value_mosi;
                            reg_we    <= 1'b1;
                        end
                    end
                    ST_RD_FETCH: begin
                        if (value_valid) begin
                            overrun <= 1'b1;
                        end
                        state <= ST_RD_LOAD;
                    end
                    ST_RD_LOAD: begin
                        if (value_valid) begin
                            overrun <= 1'b1;
                        end
                        value_miso <= reg_rdata;
                        reg_addr   <= reg_addr + AW'(1);
                        state      <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: begin
                        if (value_valid) begin
                            reg_re <= 1'b1;
                            state  <= ST_RD_FETCH;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
